// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_MEM_ACC = 3'd1,
    ARB_IF_ACC  = 3'd2,
    ARB_DONE    = 3'd3,
    ARB_DRAIN   = 3'd4
  } arb_state_e;

  // Width of the inline ack-timeout counter.
  localparam int CNT_W = 8;

  // Bit of the pipeline stall vector that holds the IF/ID stage.
  localparam int IF_HOLD_BIT = 1;

  // True while a bus cycle is outstanding (bus_ce_o asserted).
  function automatic logic in_access(input arb_state_e s);
    return (s == ARB_MEM_ACC) || (s == ARB_IF_ACC) || (s == ARB_DRAIN);
  endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates one external SRAM/bus port between instruction fetch and the
// MEM-stage load/store unit. Per pipeline cycle the data access goes first,
// then the fetch; stall requests stay high until both results are latched.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [3:0]  IF_SEL      = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [5:0]  stall_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_inst_o,
  output logic        stallreq_if_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_mem_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  arb_state_e       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             access_end;
  logic [31:0]      rdata;
  logic             unused_stall;

  // Only the IF/ID hold bit of the stall vector matters here.
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  // A stalled access is force-terminated when the counter would reach
  // ACK_TIMEOUT; a terminated access returns zero data.
  assign tmo_hit    = in_access(state) && !bus_ack_i &&
                      (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign access_end = bus_ack_i || tmo_hit;
  assign rdata      = bus_ack_i ? bus_data_i : 32'h0;

  // Stall requests drop as soon as the corresponding result is latched.
  always_comb begin
    stallreq_mem_o = mem_ce_i &&
                     ((state == ARB_IDLE) || (state == ARB_MEM_ACC));
    stallreq_if_o  = if_ce_i &&
                     ((state == ARB_IDLE) || (state == ARB_MEM_ACC) ||
                      (state == ARB_IF_ACC) || (state == ARB_DRAIN));
  end

  // Sequencer: state, registered bus outputs, result registers and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      tmo_cnt    <= '0;
      bus_ce_o   <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_addr_o <= 32'h0;
      bus_sel_o  <= 4'h0;
      bus_data_o <= 32'h0;
      bus_err_o  <= 1'b0;
      if_inst_o  <= 32'h0;
      mem_data_o <= 32'h0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        ARB_IDLE: begin
          tmo_cnt <= '0;
          if (flush) begin
            if_inst_o  <= 32'h0;
            mem_data_o <= 32'h0;
          end else if (mem_ce_i) begin
            state      <= ARB_MEM_ACC;
            bus_ce_o   <= 1'b1;
            bus_we_o   <= mem_we_i;
            bus_addr_o <= mem_addr_i;
            bus_sel_o  <= mem_sel_i;
            bus_data_o <= mem_data_i;
          end else if (if_ce_i) begin
            state      <= ARB_IF_ACC;
            bus_ce_o   <= 1'b1;
            bus_we_o   <= 1'b0;
            bus_addr_o <= if_addr_i;
            bus_sel_o  <= IF_SEL;
            bus_data_o <= 32'h0;
          end
        end

        ARB_MEM_ACC: begin
          if (access_end) begin
            tmo_cnt   <= '0;
            bus_err_o <= tmo_hit;
            if (flush) begin
              // Access finished, but the pipeline is discarding it.
              state    <= ARB_IDLE;
              bus_ce_o <= 1'b0;
              bus_we_o <= 1'b0;
            end else begin
              mem_data_o <= bus_we_o ? 32'h0 : rdata;
              if (if_ce_i) begin
                // Switch straight to the fetch with no idle bus cycle.
                state      <= ARB_IF_ACC;
                bus_we_o   <= 1'b0;
                bus_addr_o <= if_addr_i;
                bus_sel_o  <= IF_SEL;
                bus_data_o <= 32'h0;
              end else begin
                state    <= ARB_DONE;
                bus_ce_o <= 1'b0;
                bus_we_o <= 1'b0;
              end
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (flush) state <= ARB_DRAIN;
          end
        end

        ARB_IF_ACC: begin
          if (access_end) begin
            tmo_cnt   <= '0;
            bus_err_o <= tmo_hit;
            bus_ce_o  <= 1'b0;
            if (flush) begin
              state <= ARB_IDLE;
            end else begin
              if_inst_o <= rdata;
              state     <= ARB_DONE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (flush) state <= ARB_DRAIN;
          end
        end

        ARB_DONE: begin
          if (flush) begin
            state      <= ARB_IDLE;
            if_inst_o  <= 32'h0;
            mem_data_o <= 32'h0;
          end else if (!stall_i[IF_HOLD_BIT]) begin
            state <= ARB_IDLE;
          end
        end

        ARB_DRAIN: begin
          // The bus cycle must still complete (a store is never cancelled);
          // whatever it returns is thrown away.
          if (access_end) begin
            tmo_cnt   <= '0;
            bus_err_o <= tmo_hit;
            bus_ce_o  <= 1'b0;
            bus_we_o  <= 1'b0;
            state     <= ARB_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= ARB_IDLE;
          bus_ce_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small ack-delay bus responder.
module tb_sram_port_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        stallreq_if_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stallreq_mem_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  // Bus responder controls.
  logic        ack_en;
  int          ack_delay;
  int          wait_cnt;
  int          acc_cnt;

  sram_port_arbiter #(.ACK_TIMEOUT(TMO), .IF_SEL(4'b1111)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_i(stall_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
    .stallreq_if_o(stallreq_if_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .stallreq_mem_o(stallreq_mem_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // Memory contents seen by the bench.
  function automatic logic [31:0] rd_map(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h2408_0001;
      32'h8000_0004: return 32'h3C01_1234;
      32'h8040_0000: return 32'h1234_5678;
      default:       return ~a;
    endcase
  endfunction

  assign bus_data_i = rd_map(bus_addr_o);
  assign bus_ack_i  = ack_en && bus_ce_o && (wait_cnt == ack_delay);

  // Wait-state counter of the responder and completed-access counter.
  always @(posedge clk) begin
    if (!bus_ce_o || bus_ack_i) wait_cnt <= 0;
    else                        wait_cnt <= wait_cnt + 1;
    if (bus_ce_o && bus_ack_i)  acc_cnt  <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int err_pulses;
    int acc_base;

    wait_cnt   = 0;
    acc_cnt    = 0;
    rst        = 1'b1;
    flush      = 1'b0;
    stall_i    = 6'b0;
    if_ce_i    = 1'b0;
    if_addr_i  = 32'h0;
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0;
    mem_sel_i  = 4'h0;
    mem_data_i = 32'h0;
    ack_en     = 1'b1;
    ack_delay  = 0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_bus_ce", 32'(bus_ce_o), 32'd0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_inst", if_inst_o, 32'h0);
    chk("rst_mdata", mem_data_o, 32'h0);
    chk("rst_err", 32'(bus_err_o), 32'd0);

    // Fetch only, ack in the first bus cycle
    if_ce_i   = 1'b1;
    if_addr_i = 32'h8000_0000;
    #1;
    chk("f1_stall_c0", 32'(stallreq_if_o), 32'd1);
    step();
    chk("f1_ce", 32'(bus_ce_o), 32'd1);
    chk("f1_addr", bus_addr_o, 32'h8000_0000);
    chk("f1_sel", 32'(bus_sel_o), 32'hF);
    chk("f1_we", 32'(bus_we_o), 32'd0);
    chk("f1_stall_c1", 32'(stallreq_if_o), 32'd1);
    step();
    chk("f1_ce_done", 32'(bus_ce_o), 32'd0);
    chk("f1_stall_done", 32'(stallreq_if_o), 32'd0);
    chk("f1_inst", if_inst_o, 32'h2408_0001);
    if_ce_i = 1'b0;
    step();

    // Load + fetch, ack after two wait states
    ack_delay  = 2;
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h8040_0000;
    mem_sel_i  = 4'hF;
    if_ce_i    = 1'b1;
    if_addr_i  = 32'h8000_0004;
    #1;
    chk("lf_smem_idle", 32'(stallreq_mem_o), 32'd1);
    step();
    chk("lf_mem_addr", bus_addr_o, 32'h8040_0000);
    chk("lf_mem_ce", 32'(bus_ce_o), 32'd1);
    step();
    step();
    chk("lf_smem_ack", 32'(stallreq_mem_o), 32'd1);
    step();
    chk("lf_if_ce", 32'(bus_ce_o), 32'd1);
    chk("lf_if_addr", bus_addr_o, 32'h8000_0004);
    chk("lf_smem_drop", 32'(stallreq_mem_o), 32'd0);
    chk("lf_sif_high", 32'(stallreq_if_o), 32'd1);
    chk("lf_mdata", mem_data_o, 32'h1234_5678);
    step();
    step();
    step();
    chk("lf_sif_drop", 32'(stallreq_if_o), 32'd0);
    chk("lf_inst", if_inst_o, 32'h3C01_1234);
    chk("lf_ce_done", 32'(bus_ce_o), 32'd0);
    mem_ce_i = 1'b0;
    if_ce_i  = 1'b0;
    step();

    // Store: write data held until the ack, load result forced to zero
    ack_delay  = 1;
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b1;
    mem_addr_i = 32'h8040_0010;
    mem_sel_i  = 4'b0011;
    mem_data_i = 32'hDEAD_BEEF;
    step();
    mem_data_i = 32'h0;
    chk("st_we", 32'(bus_we_o), 32'd1);
    chk("st_sel", 32'(bus_sel_o), 32'h3);
    chk("st_data_c1", bus_data_o, 32'hDEAD_BEEF);
    step();
    chk("st_data_c2", bus_data_o, 32'hDEAD_BEEF);
    chk("st_addr_c2", bus_addr_o, 32'h8040_0010);
    step();
    chk("st_mdata", mem_data_o, 32'h0);
    chk("st_ce_done", 32'(bus_ce_o), 32'd0);
    mem_ce_i = 1'b0;
    mem_we_i = 1'b0;
    step();

    // No ack: forced termination after TMO cycles
    ack_en    = 1'b0;
    if_ce_i   = 1'b1;
    if_addr_i = 32'h8000_0008;
    step();
    err_pulses = 0;
    for (int k = 1; k <= int'(TMO); k++) begin
      step();
      if (bus_err_o) err_pulses++;
      if (k == int'(TMO) - 1) chk("to_ce_before", 32'(bus_ce_o), 32'd1);
    end
    chk("to_err_at_T", 32'(bus_err_o), 32'd1);
    chk("to_err_count", 32'(err_pulses), 32'd1);
    chk("to_ce_off", 32'(bus_ce_o), 32'd0);
    chk("to_inst", if_inst_o, 32'h0);
    chk("to_sif_done", 32'(stallreq_if_o), 32'd0);
    if_ce_i = 1'b0;
    step();
    chk("to_err_once", 32'(bus_err_o), 32'd0);
    ack_en = 1'b1;

    // Flush during a fetch, ack three cycles later
    ack_delay = 3;
    if_ce_i   = 1'b1;
    if_addr_i = 32'h8000_000C;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ce_d1", 32'(bus_ce_o), 32'd1);
    chk("fl_sif_d1", 32'(stallreq_if_o), 32'd1);
    step();
    chk("fl_ce_d2", 32'(bus_ce_o), 32'd1);
    step();
    chk("fl_ack_d3", 32'(bus_ack_i), 32'd1);
    step();
    if_ce_i = 1'b0;
    chk("fl_ce_idle", 32'(bus_ce_o), 32'd0);
    chk("fl_inst_disc", if_inst_o, 32'h0);
    step();
    chk("fl_stay_idle", 32'(bus_ce_o), 32'd0);

    // Pipeline hold in DONE: results stable, single access each
    ack_delay  = 0;
    acc_base   = acc_cnt;
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h8040_0000;
    mem_sel_i  = 4'hF;
    if_ce_i    = 1'b1;
    if_addr_i  = 32'h8000_0000;
    step();
    step();
    step();
    stall_i = 6'b000010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_inst", if_inst_o, 32'h2408_0001);
      chk("hold_mdata", mem_data_o, 32'h1234_5678);
      chk("hold_ce", 32'(bus_ce_o), 32'd0);
    end
    chk("hold_accesses", 32'(acc_cnt - acc_base), 32'd2);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    stall_i  = 6'b0;
    mem_ce_i = 1'b0;
    if_ce_i  = 1'b0;
    chk("dflush_inst", if_inst_o, 32'h0);
    chk("dflush_mdata", mem_data_o, 32'h0);
    step();

    // Ack and flush in the same cycle: data discarded, back to IDLE
    if_ce_i   = 1'b1;
    if_addr_i = 32'h8000_0000;
    step();
    flush = 1'b1;
    step();
    flush   = 1'b0;
    if_ce_i = 1'b0;
    chk("af_ce", 32'(bus_ce_o), 32'd0);
    chk("af_inst", if_inst_o, 32'h0);
    step();
    chk("af_idle", 32'(bus_ce_o), 32'd0);

    // Reset in the middle of a data access
    ack_en     = 1'b0;
    mem_ce_i   = 1'b1;
    mem_addr_i = 32'h8040_0020;
    step();
    chk("rm_ce_on", 32'(bus_ce_o), 32'd1);
    rst = 1'b1;
    step();
    chk("rm_ce_off", 32'(bus_ce_o), 32'd0);
    chk("rm_addr", bus_addr_o, 32'h0);
    rst      = 1'b0;
    mem_ce_i = 1'b0;
    step();
    chk("rm_idle", 32'(bus_ce_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one external SRAM/bus port between instruction fetch (PC register's pc/ce) and the MEM-stage load/store unit.
- Sequences each pipeline cycle's accesses: data first, then fetch.
- Raises stall requests to the pipeline controller until both results are latched.
- Holds results stable while the pipeline is held, and handles flush during an in-flight bus cycle.

Parameters:
- ACK_TIMEOUT, 16: max cycles bus_ce_o may wait for bus_ack_i before the access is force-terminated (range 2..255).
- IF_SEL, 4'b1111: byte select driven for instruction fetches.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high (1 = `RstEnable).
- flush  in  1  exception flush from pipeline controller.
- stall_i  in  6  stall vector from pipeline controller; bit1 = IF/ID held.
- if_ce_i  in  1  fetch enable (PC register ce).
- if_addr_i  in  32  fetch address (PC register pc).
- if_inst_o  out  32  fetched instruction.
- stallreq_if_o  out  1  fetch not yet served.
- mem_ce_i  in  1  data access request.
- mem_we_i  in  1  1 = store.
- mem_addr_i  in  32  data address.
- mem_sel_i  in  4  byte enables.
- mem_data_i  in  32  store data.
- mem_data_o  out  32  load data.
- stallreq_mem_o  out  1  data access not yet served.
- bus_ce_o  out  1  bus cycle active.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  32  bus address.
- bus_sel_o  out  4  bus byte select.
- bus_data_o  out  32  bus write data.
- bus_data_i  in  32  bus read data.
- bus_ack_i  in  1  bus cycle complete; sampled on posedge.
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- States: IDLE, MEM_ACC, IF_ACC, DONE, DRAIN.
- Reset (synchronous, overrides everything including mid-access): state=IDLE. All bus_* outputs, if_inst_o, mem_data_o, bus_err_o and the timeout counter = 0.
- IDLE:
  - mem_ce_i=1 -> MEM_ACC.
  - else if_ce_i=1 -> IF_ACC.
  - else stay IDLE.
- Bus outputs are registered: they load on the IDLE->*_ACC or MEM_ACC->IF_ACC transition and stay stable until ack or timeout.
  - MEM_ACC drives mem_we_i/addr/sel/data.
  - IF_ACC drives we=0, if_addr_i, sel=IF_SEL.
- MEM_ACC:
  - On bus_ack_i: capture bus_data_i into mem_data_o if a load (stores leave it 0).
  - Then go to IF_ACC if if_ce_i=1, else DONE.
- IF_ACC: on bus_ack_i, capture bus_data_i into if_inst_o, then go to DONE.
- Timeout: the counter increments each cycle in an *_ACC state without ack. At ACK_TIMEOUT:
  - terminate the access and return data 0;
  - pulse bus_err_o for one cycle;
  - proceed as if acked.
- bus_ce_o=0 in IDLE, DONE and after termination. Back-to-back MEM->IF accesses switch address on the cycle after the ack, with no idle gap.
- DONE:
  - Stall requests are low and results are valid.
  - If stall_i[1]=1, stay in DONE and hold results. No re-access, so destructive peripheral reads happen once.
  - Else go to IDLE next cycle.
- Stall requests (combinational):
  - stallreq_mem_o = mem_ce_i & state in {IDLE, MEM_ACC}.
  - stallreq_if_o = if_ce_i & state in {IDLE, MEM_ACC, IF_ACC, DRAIN}.
- Latency with 1-cycle ack: load+fetch = 3 cycles stalled, results valid in cycle 3. Fetch only = 2 cycles.
- Flush:
  - In IDLE/DONE: go to IDLE and clear both result registers.
  - In an *_ACC state: go to DRAIN, keep bus_ce_o asserted until ack or timeout, discard the data, then go to IDLE.
  - A store in flight completes; its write is not cancelled.
- Simultaneous ack and flush: the ack completes the access and the data is discarded; next state is IDLE.
- rst and flush together: rst wins.

Decomposition:
- defines.v: state encodings (`ARB_IDLE..`ARB_DRAIN), `RstEnable, `ChipEnable, `RegBus, `InstAddrBus, `NoStop.
- No sub-module; the timeout counter is inline (8 bits).

Test Plan:
- Fetch only, ack in 1 cycle, if_addr=32'h8000_0000, bus returns 32'h2408_0001 -> bus_addr_o=32'h8000_0000 with sel=1111 for 1 cycle; stallreq_if high 2 cycles; if_inst_o=32'h2408_0001 in DONE.
- Load + fetch, mem_addr=32'h8040_0000, ack delay 2 -> MEM access precedes IF; stallreq_mem drops after MEM ack; stallreq_if drops after IF ack; mem_data_o and if_inst_o both correct.
- Store 32'hDEAD_BEEF with sel=0011 -> bus_we_o=1, sel=0011, data held until ack; mem_data_o=0.
- No ack -> bus_err_o pulses exactly ACK_TIMEOUT cycles after bus_ce_o rises; if_inst_o=0; FSM reaches DONE.
- Flush in IF_ACC with ack 3 cycles later -> DRAIN holds bus_ce_o until the ack; stallreq_if stays high; data discarded; IDLE next.
- stall_i[1]=1 for 4 cycles in DONE -> results held, exactly one bus access; rst asserted mid-MEM_ACC -> bus_ce_o=0 on the next edge.
